// File: rtl/hash_bus_bridge_if.sv
// Bus-side and core-side signal bundles for the hash bridge.
// No logic, no latency: pure wiring.
// Backpressure lives in the modules that use these bundles.

// Register-bus beats between a bus initiator (master) and the bridge (slave).
interface hash_bus_if #(
  parameter int DW = 32
);
  logic          wr;
  logic [11:0]   waddr;
  logic [DW-1:0] wdata;
  logic          wr_ack;
  logic          rd;
  logic [11:0]   raddr;
  logic [DW-1:0] rdata;
  logic          read_valid;

  modport master (
    output wr, waddr, wdata, rd, raddr,
    input  wr_ack, rdata, read_valid
  );

  modport slave (
    input  wr, waddr, wdata, rd, raddr,
    output wr_ack, rdata, read_valid
  );
endinterface

// Native hash-core controls, driven by the bridge (master) into the core (slave).
interface hash_native_if #(
  parameter int AW = 32
);
  logic            start;
  logic            abort;
  logic            last;
  logic [3:0]      opcode;
  logic [AW-1:0]   data;
  logic            valid;
  logic            ready;
  logic            core_ready;
  logic            done;
  logic [8*AW-1:0] hash;
  logic            fault_inj_det;

  modport master (
    output start, abort, last, opcode, data, valid,
    input  ready, core_ready, done, hash, fault_inj_det
  );

  modport slave (
    input  start, abort, last, opcode, data, valid,
    output ready, core_ready, done, hash, fault_inj_det
  );
endinterface

// File: rtl/hash_bus_bridge.sv
// Register front end: bus writes feed a word FIFO streamed into the hash core; digest captured for reads.
// wr_ack one cycle after each write; rdata combinational; start/abort pulse the cycle after the CTRL write.
// Core ready stalls the FIFO head; a push into a full FIFO with no pop that cycle is dropped and flagged.
module hash_bus_bridge #(
  parameter int BUS_DATA_WIDTH = 32,
  parameter int ARCH_SZ        = 32,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic            clk,
  input  logic            rst,
  hash_bus_if.slave       bus_io,
  hash_native_if.master   core_io
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  localparam logic [9:0] A_CTRL   = 10'h000;
  localparam logic [9:0] A_DIN    = 10'h001;
  localparam logic [9:0] A_DLAST  = 10'h002;
  localparam logic [9:0] A_STATUS = 10'h003;
  localparam logic [9:0] A_HASH0  = 10'h040;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // FIFO storage: {last, word}
  logic [ARCH_SZ:0]  mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [PW:0]       count_q;

  logic [3:0]            opcode_q;
  logic                  start_q, abort_q, wr_ack_q;
  logic [8*ARCH_SZ-1:0]  hash_q;
  logic                  done_stk_q, fault_stk_q, ovf_stk_q, err_stk_q;

  logic [9:0] wa, ra;
  logic       ctrl_wr, abort_req, start_req, start_ok, start_err, flush;
  logic       push_req, push, pop, ovf, capture;
  logic       fifo_empty, fifo_full;
  logic       stream_vld, busy;
  logic [ARCH_SZ:0] head;
  logic [7:0] status;
  logic [BUS_DATA_WIDTH-1:0] rdata_c;

  // Byte-lane bits of the addresses carry no meaning here.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{bus_io.waddr[1:0], bus_io.raddr[1:0]};

  assign wa = bus_io.waddr[11:2];
  assign ra = bus_io.raddr[11:2];

  // Abort wins over start inside the same CTRL write; a fault in the same
  // cycle also refuses the start so the core is never kicked while faulting.
  assign ctrl_wr   = bus_io.wr && (wa == A_CTRL);
  assign abort_req = ctrl_wr && bus_io.wdata[1];
  assign start_req = ctrl_wr && !bus_io.wdata[1] && bus_io.wdata[0];
  assign start_ok  = start_req && (state_q == IDLE) && core_io.core_ready &&
                     !fault_stk_q && !core_io.fault_inj_det;
  assign start_err = start_req && !start_ok;
  assign flush     = abort_req || core_io.fault_inj_det;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign head       = mem_q[rptr_q];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // still accepted when the core is draining it.
  assign push_req = bus_io.wr && ((wa == A_DIN) || (wa == A_DLAST));
  assign pop      = stream_vld && core_io.ready;
  assign push     = push_req && (!fifo_full || pop);
  assign ovf      = push_req && fifo_full && !pop;
  assign capture  = (state_q == WAIT_DONE) && core_io.done;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; abort and fault force IDLE from anywhere
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start_ok) state_d = STREAM;
      STREAM:    if (pop && head[ARCH_SZ]) state_d = WAIT_DONE;
      WAIT_DONE: if (core_io.done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // FSM outputs: data only presented while streaming with a word queued
  always_comb begin
    stream_vld = (state_q == STREAM) && !fifo_empty;
    busy       = (state_q != IDLE);
  end

  // FIFO pointers and occupancy; flush empties the FIFO in one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; contents are never observed while empty, so no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {(wa == A_DLAST), bus_io.wdata};
  end

  // Control pulses, opcode latch, digest shadow and sticky status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q     <= 1'b0;
      abort_q     <= 1'b0;
      wr_ack_q    <= 1'b0;
      opcode_q    <= '0;
      hash_q      <= '0;
      done_stk_q  <= 1'b0;
      fault_stk_q <= 1'b0;
      ovf_stk_q   <= 1'b0;
      err_stk_q   <= 1'b0;
    end else begin
      start_q  <= start_ok;
      abort_q  <= abort_req;
      wr_ack_q <= bus_io.wr;
      if (start_ok) opcode_q <= bus_io.wdata[7:4];
      if (capture)  hash_q   <= core_io.hash;
      if (start_ok)     done_stk_q <= 1'b0;
      else if (capture) done_stk_q <= 1'b1;
      if (core_io.fault_inj_det) fault_stk_q <= 1'b1;
      else if (abort_req)        fault_stk_q <= 1'b0;
      if (ovf)       ovf_stk_q <= 1'b1;
      if (start_err) err_stk_q <= 1'b1;
    end
  end

  // Read mux: STATUS and the eight digest words, everything else reads 0
  always_comb begin
    status  = {err_stk_q, ovf_stk_q, fault_stk_q, fifo_empty,
               fifo_full, done_stk_q, core_io.core_ready, busy};
    rdata_c = '0;
    if (bus_io.rd) begin
      if (ra == A_STATUS) rdata_c = BUS_DATA_WIDTH'(status);
      for (int i = 0; i < 8; i++) begin
        if (ra == A_HASH0 + 10'(i)) rdata_c = hash_q[i*ARCH_SZ +: ARCH_SZ];
      end
    end
  end

  assign bus_io.wr_ack     = wr_ack_q;
  assign bus_io.rdata      = rdata_c;
  assign bus_io.read_valid = bus_io.rd;

  assign core_io.start  = start_q;
  assign core_io.abort  = abort_q;
  assign core_io.opcode = opcode_q;
  assign core_io.valid  = stream_vld;
  assign core_io.data   = stream_vld ? head[ARCH_SZ-1:0] : '0;
  assign core_io.last   = stream_vld && head[ARCH_SZ];

endmodule
